multicycle_control_fsm: RTL and testbench

- Multicycle sequencer for the 32-bit processor datapath: drives PC, IR, register bank, ALU, data memory and I/O control lines state by state.
- Sits alongside the datapath inside the top-level processor and replaces the single-cycle combinational control decode.
- Manages the IN instruction handshake with the 20-bit switch input (waits for a debounced press) and the sticky halt.

---
 rtl/multicycle_control_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer for the 32-bit datapath: steps PC/IR/register/ALU/memory/I-O
// strobes through one state per cycle, with a synchronised IN handshake and a sticky halt.
module multicycle_control_fsm #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             input_valid,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_read,
  output logic             mem_write,
  output logic             out_en,
  output logic             halt,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    IN_WAIT  = 4'd11,
    OUT      = 4'd12,
    HALTED   = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b000010;
  localparam logic [5:0] OP_SW   = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000110;
  localparam logic [5:0] OP_IN   = 6'b000111;
  localparam logic [5:0] OP_OUT  = 6'b001000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t                 cur;
  state_t                 nxt;
  logic [5:0]             op_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   in_edge;
  logic                   cnt_inc;

  // Edge detector runs continuously, so a level that was already high before IN_WAIT never fires.
  assign in_edge = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign state   = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= FETCH;
      op_q        <= '0;
      sync_q      <= '0;
      sync_prev   <= 1'b0;
      instr_count <= '0;
    end else begin
      cur       <= nxt;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], input_valid};
      sync_prev <= sync_q[SYNC_STAGES-1];
      if (cur == DECODE) op_q <= opcode;
      if (cnt_inc) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    nxt       = cur;
    cnt_inc   = 1'b0;
    ir_write  = 1'b0;
    pc_en     = 1'b0;
    pc_src    = 2'd0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    alu_src   = 1'b0;
    alu_op    = 2'd0;
    reg_dst   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    out_en    = 1'b0;
    halt      = 1'b0;
    illegal   = 1'b0;
    case (cur)
      FETCH: begin
        ir_write = 1'b1;
        pc_en    = 1'b1;
        nxt      = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_R:          nxt = EXEC_R;
          OP_ADDI:       nxt = EXEC_I;
          OP_LW, OP_SW:  nxt = MEM_ADDR;
          OP_BEQ, OP_BNE: nxt = BRANCH;
          OP_J:          nxt = JUMP;
          OP_IN:         nxt = IN_WAIT;
          OP_OUT:        nxt = OUT;
          OP_HALT: begin
            nxt     = HALTED;
            cnt_inc = 1'b1;
          end
          default: begin
            illegal = 1'b1;
            nxt     = FETCH;
          end
        endcase
      end
      EXEC_R: begin
        alu_op  = 2'd2;
        reg_dst = 1'b1;
        nxt     = ALU_WB;
      end
      EXEC_I: begin
        alu_src = 1'b1;
        nxt     = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == OP_R);
        cnt_inc   = 1'b1;
        nxt       = FETCH;
      end
      MEM_ADDR: begin
        alu_src = 1'b1;
        nxt     = (op_q == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        nxt      = MEM_WB;
      end
      MEM_WB: begin
        mem_read  = 1'b1;
        reg_write = 1'b1;
        wb_sel    = 2'd1;
        cnt_inc   = 1'b1;
        nxt       = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        cnt_inc   = 1'b1;
        nxt       = FETCH;
      end
      BRANCH: begin
        alu_op = 2'd1;
        if ((op_q == OP_BEQ && zero) || (op_q == OP_BNE && !zero)) begin
          pc_en  = 1'b1;
          pc_src = 2'd1;
        end
        cnt_inc = 1'b1;
        nxt     = FETCH;
      end
      JUMP: begin
        pc_en   = 1'b1;
        pc_src  = 2'd2;
        cnt_inc = 1'b1;
        nxt     = FETCH;
      end
      IN_WAIT: begin
        if (in_edge) begin
          reg_write = 1'b1;
          wb_sel    = 2'd2;
          cnt_inc   = 1'b1;
          nxt       = FETCH;
        end
      end
      OUT: begin
        out_en  = 1'b1;
        cnt_inc = 1'b1;
        nxt     = FETCH;
      end
      HALTED: halt = 1'b1;
      default: nxt = FETCH;
    endcase
    // Reset is asynchronous, so strobes are killed combinationally the moment it rises.
    if (reset) begin
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      pc_src    = 2'd0;
      reg_write = 1'b0;
      wb_sel    = 2'd0;
      alu_src   = 1'b0;
      alu_op    = 2'd0;
      reg_dst   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      out_en    = 1'b0;
      halt      = 1'b0;
      illegal   = 1'b0;
      cnt_inc   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed instruction sequences push per-cycle
// expected state/strobes/count records; a negedge monitor pops and compares every cycle.
module tb_multicycle_control_fsm;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        input_valid;
  logic        ir_write, pc_en, reg_write, alu_src, reg_dst;
  logic        mem_read, mem_write, out_en, halt, illegal;
  logic [1:0]  pc_src, wb_sel, alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  multicycle_control_fsm #(.SYNC_STAGES(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .input_valid(input_valid),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_read(mem_read), .mem_write(mem_write), .out_en(out_en), .halt(halt),
    .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector layout: ir_write,pc_en,pc_src[1:0],reg_write,wb_sel[1:0],alu_src,
  // alu_op[1:0],reg_dst,mem_read,mem_write,out_en,halt,illegal
  localparam logic [15:0] IR   = 16'h8000, PCEN = 16'h4000, PCS1 = 16'h1000, PCS2 = 16'h2000;
  localparam logic [15:0] RW   = 16'h0800, WB1  = 16'h0200, WB2  = 16'h0400, ASRC = 16'h0100;
  localparam logic [15:0] AOP1 = 16'h0040, AOP2 = 16'h0080, RDST = 16'h0020, MRD  = 16'h0010;
  localparam logic [15:0] MWR  = 16'h0008, OEN  = 16'h0004, HLT  = 16'h0002, ILL  = 16'h0001;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [15:0] mask;
    logic [31:0] cnt;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] exp_cnt;
  int          checks;
  int          errors;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobes are always checked; selector fields only where their value is defined.
  task automatic expect_cyc(input logic [3:0] st, input logic [15:0] ctrl,
                            input bit alu_chk, input bit last);
    logic [15:0] m;
    m = 16'hC81F;
    if ((ctrl & PCEN) != 16'h0) m = m | 16'h3000;
    if ((ctrl & RW) != 16'h0) m = m | 16'h0620;
    if (alu_chk) m = m | 16'h01C0;
    exp_q.push_back('{st, ctrl, m, exp_cnt});
    if (last) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic expect_reset();
    exp_cnt = 32'd0;
    exp_q.push_back('{4'd0, 16'h0000, 16'hFFFF, 32'd0});
  endtask

  task automatic fetch_decode(input logic [5:0] op);
    opcode = op;
    expect_cyc(4'd0, IR | PCEN, 1'b0, 1'b0);
    expect_cyc(4'd1, 16'h0000, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [15:0] act;
    rec_t        r;
    act = {ir_write, pc_en, pc_src, reg_write, wb_sel, alu_src, alu_op, reg_dst,
           mem_read, mem_write, out_en, halt, illegal};
    checks++;
    if ((reg_write + mem_write + out_en) > 1) begin
      errors++;
      $display("FAIL exclusive_writes: t=%0t reg_write=%b mem_write=%b out_en=%b, required at most one",
               $time, reg_write, mem_write, out_en);
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow: t=%0t state=%0d, no expected record queued", $time, state);
    end else begin
      r = exp_q.pop_front();
      checks++;
      if (state !== r.st) begin
        errors++;
        $display("FAIL state: t=%0t got %0d, expected %0d", $time, state, r.st);
      end
      checks++;
      if ((act & r.mask) !== (r.ctrl & r.mask)) begin
        errors++;
        $display("FAIL ctrl: t=%0t state=%0d got %h, expected %h (mask %h)",
                 $time, state, act & r.mask, r.ctrl & r.mask, r.mask);
      end
      checks++;
      if (instr_count !== r.cnt) begin
        errors++;
        $display("FAIL instr_count: t=%0t got %0d, expected %0d", $time, instr_count, r.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    exp_cnt     = 32'd0;
    reset       = 1'b1;
    opcode      = 6'b000000;
    zero        = 1'b0;
    input_valid = 1'b0;
    expect_reset();
    #17;
    reset = 1'b0;

    // ADDI: 0,1,3,8 then FETCH with count 1
    fetch_decode(6'b000001);
    expect_cyc(4'd3, ASRC, 1'b1, 1'b0);
    expect_cyc(4'd8, RW, 1'b0, 1'b1);
    cycles(4);

    // R-type
    fetch_decode(6'b000000);
    expect_cyc(4'd2, AOP2, 1'b1, 1'b0);
    expect_cyc(4'd8, RW | RDST, 1'b0, 1'b1);
    cycles(4);

    // LW (5 cycles) then SW (4 cycles)
    fetch_decode(6'b000010);
    expect_cyc(4'd4, ASRC, 1'b1, 1'b0);
    expect_cyc(4'd5, MRD, 1'b0, 1'b0);
    expect_cyc(4'd6, MRD | RW | WB1, 1'b0, 1'b1);
    cycles(5);
    fetch_decode(6'b000011);
    expect_cyc(4'd4, ASRC, 1'b1, 1'b0);
    expect_cyc(4'd7, MWR, 1'b0, 1'b1);
    cycles(4);

    // Branches: BEQ taken/not, BNE not/taken
    zero = 1'b1;
    fetch_decode(6'b000100);
    expect_cyc(4'd9, PCEN | PCS1 | AOP1, 1'b1, 1'b1);
    cycles(3);
    zero = 1'b0;
    fetch_decode(6'b000100);
    expect_cyc(4'd9, AOP1, 1'b1, 1'b1);
    cycles(3);
    zero = 1'b1;
    fetch_decode(6'b000101);
    expect_cyc(4'd9, AOP1, 1'b1, 1'b1);
    cycles(3);
    zero = 1'b0;
    fetch_decode(6'b000101);
    expect_cyc(4'd9, PCEN | PCS1 | AOP1, 1'b1, 1'b1);
    cycles(3);

    // J, with input_valid raised early so it is a settled level before IN
    input_valid = 1'b1;
    fetch_decode(6'b000110);
    expect_cyc(4'd10, PCEN | PCS2, 1'b0, 1'b1);
    cycles(3);

    // IN: held level ignored; drop at c4, raise at c8, write pulse in c10
    fetch_decode(6'b000111);
    for (int i = 2; i < 10; i++) expect_cyc(4'd11, 16'h0000, 1'b0, 1'b0);
    expect_cyc(4'd11, RW | WB2, 1'b0, 1'b1);
    cycles(4);
    input_valid = 1'b0;
    cycles(4);
    input_valid = 1'b1;
    cycles(3);

    // OUT
    input_valid = 1'b0;
    fetch_decode(6'b001000);
    expect_cyc(4'd12, OEN, 1'b0, 1'b1);
    cycles(3);

    // Illegal opcode: pulse in DECODE, count unchanged
    opcode = 6'b101010;
    expect_cyc(4'd0, IR | PCEN, 1'b0, 1'b0);
    expect_cyc(4'd1, ILL, 1'b0, 1'b0);
    cycles(2);

    // Reset during MEM_WR of an SW
    fetch_decode(6'b000011);
    expect_cyc(4'd4, ASRC, 1'b1, 1'b0);
    expect_reset();
    cycles(3);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;

    // Reset during IN_WAIT
    fetch_decode(6'b000111);
    expect_cyc(4'd11, 16'h0000, 1'b0, 1'b0);
    expect_cyc(4'd11, 16'h0000, 1'b0, 1'b0);
    expect_reset();
    cycles(4);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;

    // HALT: counted on entry, sticky for 100 cycles while input_valid toggles
    opcode = 6'b111111;
    expect_cyc(4'd0, IR | PCEN, 1'b0, 1'b0);
    expect_cyc(4'd1, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) expect_cyc(4'd13, HLT, 1'b0, 1'b0);
    cycles(2);
    for (int i = 0; i < 100; i++) begin
      input_valid = ((i / 3) % 2) == 1;
      cycles(1);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
